// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receive datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_MAX_DATA_BITS      = 8;
    localparam int UART_DEFAULT_FIFO_DEPTH = 4;

    // One received byte plus its stop-bit status; narrow bytes are zero-extended.
    typedef struct packed {
        logic                          frame_err;
        logic [UART_MAX_DATA_BITS-1:0] data;
    } rx_entry_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO with wrap-bit pointers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_addr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_addr_w:0] r_wr_ptr;
    logic [c_addr_w:0] r_rd_ptr;

    logic w_do_push;
    logic w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                   (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
    assign count = r_wr_ptr - r_rd_ptr;

    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    assign pop_data = r_mem[r_rd_ptr[c_addr_w-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[c_addr_w-1:0]] <= push_data;
                r_wr_ptr                      <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rx_byte_assembler.sv
// ============================================================================
// Module      : rx_byte_assembler
// Description : Assembles LSB-first UART bits into tagged bytes and buffers them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_byte_assembler
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_MAX_DATA_BITS,
    parameter int FIFO_DEPTH = UART_DEFAULT_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          active_rx,
    input  logic                          bit_ready,
    input  logic                          rx_bit,
    input  logic                          done,
    input  logic                          framing_err,
    output logic [DATA_BITS-1:0]          data_out,
    output logic                          data_out_frame_err,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          len_err,
    input  logic                          clear_err
);

    localparam int                 c_cnt_w    = $clog2(DATA_BITS + 2);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DATA_BITS);
    localparam logic [c_cnt_w-1:0] c_cnt_sat  = c_cnt_w'(DATA_BITS + 1);

    logic [DATA_BITS-1:0] r_shift;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_active_d;
    logic                 r_len_err;
    logic                 r_overrun;

    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [c_cnt_w-1:0]   w_count_nxt;
    logic                 w_abort;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_full;
    logic                 w_empty;
    rx_entry_t            w_push_entry;
    rx_entry_t            w_pop_entry;

    // A bit arriving with done is folded in before the frame is judged.
    always_comb begin
        w_shift_nxt = r_shift;
        w_count_nxt = r_count;
        if (bit_ready) begin
            w_shift_nxt = {rx_bit, r_shift[DATA_BITS-1:1]};
            if (r_count != c_cnt_sat) begin
                w_count_nxt = r_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_push_entry                     = '0;
        w_push_entry.frame_err           = framing_err;
        w_push_entry.data[DATA_BITS-1:0] = w_shift_nxt;
    end

    assign w_abort = r_active_d & ~active_rx & ~done;
    assign w_push  = done & (w_count_nxt == c_cnt_full);
    assign w_pop   = data_out_ready & ~w_empty;
    assign w_drop  = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_count    <= '0;
            r_active_d <= 1'b0;
            r_len_err  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_active_d <= active_rx;
            if (done || w_abort) begin
                r_shift <= '0;
                r_count <= '0;
            end else begin
                r_shift <= w_shift_nxt;
                r_count <= w_count_nxt;
            end
            r_len_err <= done & (w_count_nxt != c_cnt_full);
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clear_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .pop_data  (w_pop_entry),
        .full      (w_full),
        .empty     (w_empty),
        .count     (fifo_count)
    );

    assign data_out           = w_pop_entry.data[DATA_BITS-1:0];
    assign data_out_frame_err = w_pop_entry.frame_err;
    assign data_out_valid     = ~w_empty;
    assign overrun            = r_overrun;
    assign len_err            = r_len_err;

endmodule

`default_nettype wire

// File: tb/tb_rx_byte_assembler.sv
// ============================================================================
// Module      : tb_rx_byte_assembler
// Description : Self-checking bench for rx_byte_assembler with a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_byte_assembler;

    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       active_rx = 1'b0;
    logic       bit_ready = 1'b0;
    logic       rx_bit = 1'b0;
    logic       done = 1'b0;
    logic       framing_err = 1'b0;
    logic [7:0] data_out;
    logic       data_out_frame_err;
    logic       data_out_valid;
    logic       data_out_ready = 1'b0;
    logic [2:0] fifo_count;
    logic       overrun;
    logic       len_err;
    logic       clear_err = 1'b0;

    int tests = 0;
    int fails = 0;

    // Model state: FIFO contents as {frame_err, byte}, sticky overrun, last len_err.
    logic [8:0] mq[$];
    bit         m_ovr = 0;
    bit         m_len = 0;

    always #5 clk = ~clk;

    rx_byte_assembler #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .active_rx          (active_rx),
        .bit_ready          (bit_ready),
        .rx_bit             (rx_bit),
        .done               (done),
        .framing_err        (framing_err),
        .data_out           (data_out),
        .data_out_frame_err (data_out_frame_err),
        .data_out_valid     (data_out_valid),
        .data_out_ready     (data_out_ready),
        .fifo_count         (fifo_count),
        .overrun            (overrun),
        .len_err            (len_err),
        .clear_err          (clear_err)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        active_rx = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            repeat ($urandom_range(0, 1)) tick();
            bit_ready = 1'b1;
            rx_bit    = (i < 8) ? b[i] : 1'b0;
            tick();
            bit_ready = 1'b0;
        end
    endtask

    // Sends a frame and updates the model from the frame rules.
    task automatic send_frame(input logic [7:0] b, input logic fe, input int nbits,
                              input bit pop_at_done);
        send_bits(b, nbits);
        done           = 1'b1;
        framing_err    = fe;
        data_out_ready = pop_at_done;
        if (pop_at_done && mq.size() > 0) void'(mq.pop_front());
        if (nbits == DATA_BITS) begin
            if (mq.size() < FIFO_DEPTH) mq.push_back({fe, b});
            else m_ovr = 1;
        end
        m_len = (nbits != DATA_BITS);
        tick();
        done           = 1'b0;
        framing_err    = 1'b0;
        data_out_ready = 1'b0;
        active_rx      = 1'b0;
    endtask

    task automatic pop_one();
        data_out_ready = 1'b1;
        if (mq.size() > 0) void'(mq.pop_front());
        tick();
        data_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        tests++;
        if ({data_out_valid, fifo_count, overrun, len_err, data_out, data_out_frame_err} !== 15'd0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b cnt=%0d ovr=%b len=%b d=%h fe=%b required all zero",
                     data_out_valid, fifo_count, overrun, len_err, data_out, data_out_frame_err);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b0, 8, 0);
        tests++;
        if (data_out_valid !== 1'b1 || data_out !== 8'hA5 || data_out_frame_err !== 1'b0 || fifo_count !== 3'd1) begin
            fails++;
            $display("FAIL basic_a5: got v=%b d=%h fe=%b cnt=%0d required v=1 d=a5 fe=0 cnt=1",
                     data_out_valid, data_out, data_out_frame_err, fifo_count);
        end
        pop_one();
        tests++;
        if (data_out_valid !== 1'b0 || fifo_count !== 3'd0) begin
            fails++;
            $display("FAIL basic_pop: got v=%b cnt=%0d required v=0 cnt=0", data_out_valid, fifo_count);
        end
    endtask

    task automatic test_frame_err();
        bit seen_len = 0;
        send_frame(8'h3C, 1'b1, 8, 0);
        seen_len = len_err;
        tests++;
        if (data_out !== 8'h3C || data_out_frame_err !== 1'b1 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL frame_err_tag: got d=%h fe=%b ovr=%b required d=3c fe=1 ovr=0",
                     data_out, data_out_frame_err, overrun);
        end
        tick();
        seen_len = seen_len | len_err;
        tests++;
        if (seen_len !== 1'b0) begin
            fails++;
            $display("FAIL frame_err_len: got len_err=%b required 0", seen_len);
        end
        pop_one();
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b0, 8, 0);
            if (i == 4) begin
                tests++;
                if (overrun !== 1'b0 || fifo_count !== 3'd4) begin
                    fails++;
                    $display("FAIL overrun_at_four: got ovr=%b cnt=%0d required ovr=0 cnt=4", overrun, fifo_count);
                end
            end
        end
        tests++;
        if (fifo_count !== 3'd4 || overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_set: got cnt=%0d ovr=%b required cnt=4 ovr=1", fifo_count, overrun);
        end
        for (int i = 1; i <= 4; i++) begin
            tests++;
            if (data_out_valid !== 1'b1 || data_out !== 8'(i)) begin
                fails++;
                $display("FAIL overrun_drain: got v=%b d=%h required v=1 d=%h", data_out_valid, data_out, 8'(i));
            end
            pop_one();
        end
        tests++;
        if (data_out_valid !== 1'b0 || overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_after_drain: got v=%b ovr=%b required v=0 ovr=1", data_out_valid, overrun);
        end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        m_ovr = 0;
        tests++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL overrun_clear: got %b required 0", overrun);
        end
    endtask

    task automatic test_full_pop_push();
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b0, 8, 0);
        tests++;
        if (fifo_count !== 3'd4 || data_out !== 8'h10) begin
            fails++;
            $display("FAIL full_before: got cnt=%0d d=%h required cnt=4 d=10", fifo_count, data_out);
        end
        send_frame(8'h77, 1'b0, 8, 1);
        tests++;
        if (fifo_count !== 3'd4 || overrun !== 1'b0 || data_out !== 8'h11) begin
            fails++;
            $display("FAIL full_pop_push: got cnt=%0d ovr=%b d=%h required cnt=4 ovr=0 d=11",
                     fifo_count, overrun, data_out);
        end
        while (mq.size() > 0) begin
            tests++;
            if (data_out !== mq[0][7:0]) begin
                fails++;
                $display("FAIL full_drain: got d=%h required %h", data_out, mq[0][7:0]);
            end
            pop_one();
        end
    endtask

    task automatic test_len_err();
        send_frame(8'h15, 1'b0, 5, 0);
        tests++;
        if (len_err !== 1'b1 || fifo_count !== 3'd0) begin
            fails++;
            $display("FAIL len_err_pulse: got len=%b cnt=%0d required len=1 cnt=0", len_err, fifo_count);
        end
        tick();
        tests++;
        if (len_err !== 1'b0) begin
            fails++;
            $display("FAIL len_err_width: got %b required 0", len_err);
        end
        send_frame(8'h5A, 1'b0, 8, 0);
        tests++;
        if (data_out !== 8'h5A || fifo_count !== 3'd1 || len_err !== 1'b0) begin
            fails++;
            $display("FAIL len_err_recover: got d=%h cnt=%0d len=%b required d=5a cnt=1 len=0",
                     data_out, fifo_count, len_err);
        end
        pop_one();
    endtask

    task automatic test_abort();
        send_bits(8'h07, 3);
        active_rx = 1'b0;
        tick();
        tick();
        tests++;
        if (len_err !== 1'b0 || fifo_count !== 3'd0) begin
            fails++;
            $display("FAIL abort_quiet: got len=%b cnt=%0d required len=0 cnt=0", len_err, fifo_count);
        end
        send_frame(8'hFF, 1'b0, 8, 0);
        tests++;
        if (data_out !== 8'hFF || fifo_count !== 3'd1 || len_err !== 1'b0) begin
            fails++;
            $display("FAIL abort_recover: got d=%h cnt=%0d len=%b required d=ff cnt=1 len=0",
                     data_out, fifo_count, len_err);
        end
        pop_one();
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h99, 1'b1, 8, 0);
        send_bits(8'h05, 3);
        rst_n     = 1'b0;
        active_rx = 1'b0;
        tick();
        mq.delete();
        m_ovr = 0;
        tests++;
        if ({data_out_valid, fifo_count, overrun, len_err, data_out, data_out_frame_err} !== 15'd0) begin
            fails++;
            $display("FAIL midframe_reset: got v=%b cnt=%0d ovr=%b len=%b d=%h fe=%b required all zero",
                     data_out_valid, fifo_count, overrun, len_err, data_out, data_out_frame_err);
        end
        rst_n = 1'b1;
        tick();
        send_frame(8'hC3, 1'b0, 8, 0);
        tests++;
        if (data_out !== 8'hC3 || fifo_count !== 3'd1 || len_err !== 1'b0 || data_out_frame_err !== 1'b0) begin
            fails++;
            $display("FAIL midframe_recover: got d=%h cnt=%0d len=%b fe=%b required d=c3 cnt=1 len=0 fe=0",
                     data_out, fifo_count, len_err, data_out_frame_err);
        end
        pop_one();
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       fe;
        int         r;
        int         nbits;
        for (int f = 0; f < 40; f++) begin
            b     = 8'($urandom);
            fe    = 1'($urandom_range(0, 1));
            r     = $urandom_range(0, 9);
            nbits = (r < 7) ? DATA_BITS : (r == 7) ? $urandom_range(1, 7) : $urandom_range(9, 10);
            send_frame(b, fe, nbits, $urandom_range(0, 3) == 0);
            tests++;
            if (fifo_count !== 3'(mq.size()) || data_out_valid !== (mq.size() > 0) ||
                overrun !== m_ovr || len_err !== m_len ||
                (mq.size() > 0 && {data_out_frame_err, data_out} !== mq[0])) begin
                fails++;
                $display("FAIL random_frame%0d: got cnt=%0d v=%b ovr=%b len=%b head=%h required cnt=%0d ovr=%b len=%b head=%h",
                         f, fifo_count, data_out_valid, overrun, len_err, {data_out_frame_err, data_out},
                         mq.size(), m_ovr, m_len, (mq.size() > 0) ? mq[0] : 9'h0);
            end
            repeat ($urandom_range(0, 2)) begin
                tests++;
                if (mq.size() > 0 && {data_out_frame_err, data_out} !== mq[0]) begin
                    fails++;
                    $display("FAIL random_pop: got head=%h required %h", {data_out_frame_err, data_out}, mq[0]);
                end
                pop_one();
            end
            if ($urandom_range(0, 4) == 0) begin
                clear_err = 1'b1;
                tick();
                clear_err = 1'b0;
                m_ovr = 0;
                tests++;
                if (overrun !== 1'b0) begin
                    fails++;
                    $display("FAIL random_clear: got ovr=%b required 0", overrun);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_err();
        test_overrun();
        test_full_pop_push();
        test_len_err();
        test_abort();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
